exe_mem_pipe: RTL
=================

# exe_mem_pipe

Parametrised EXE→MEM pipeline register for the CPU datapath. It adds the following to the plain EXE/MEM latch:
- a valid/ready handshake with a one-entry skid buffer, so a MEM-side stall does not combinationally reach back into EXE;
- a synchronous flush;
- control gating, so bubbles never write memory or the register file;
- forwarding and load-use hazard outputs for the EXE stage;
- a saturating stall counter.

It sits between the ALU/EXE stage and the data-memory stage.

## Interface
Parameters:
- DSIZE, 32, datapath width (result, store data)
- ASIZE, 5, register-file address width
- CNT_W, 16, stall-counter width

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- flush  in  1  kill every held entry and the current input
- in_valid  in  1  EXE presents an instruction
- in_ready  out  1  stage can accept (registered)
- wen_in, mem_write_in, mem_read_in, mem_to_reg_in  in  1 each  control from EXE
- rdata2_in  in  DSIZE  store data
- result_in  in  DSIZE  ALU result / address
- waddr_in  in  ASIZE  destination register
- out_valid  out  1  MEM-side entry valid
- out_ready  in  1  MEM accepts the entry this cycle
- wen_out, mem_write_out, mem_read_out, mem_to_reg_out  out  1 each  control, gated by out_valid
- rdata2_out, result_out  out  DSIZE  payload
- waddr_out  out  ASIZE  payload
- hz_raddr1, hz_raddr2  in  ASIZE  source registers of the instruction now in EXE
- fwd_en  out  1  out_valid & wen_out & ~mem_read_out & waddr_out≠0
- fwd_data  out  DSIZE  equals result_out
- load_use  out  1  out_valid & mem_read_out & wen_out & waddr_out≠0 & (waddr_out==hz_raddr1 | waddr_out==hz_raddr2)
- stall_cnt  out  CNT_W  cycles with out_valid & ~out_ready, saturating

## Operation
Storage:
- A main register (drives the outputs) and a skid register, each holding the full payload plus a valid bit (m_v, s_v).
- out_valid = m_v. in_ready = ~s_v, taken from the flop, with no combinational path from out_ready.

Accept and transfer:
- Input accept: acc = in_valid & in_ready & ~flush.
- Output transfer: xfer = m_v & out_ready.

Per rising edge when rst=0 and flush=0:
- Main empty, or xfer with s_v=0: main ← input and m_v ← acc.
- xfer with s_v=1: main ← skid, m_v ← 1, s_v ← 0. in_ready was 0, so no input is accepted that cycle.
- m_v=1 with no xfer, and acc: skid ← input, s_v ← 1.
- m_v=1 with no xfer, and no acc: hold everything.

Flush and reset:
- flush=1 (and rst=0): m_v ← 0 and s_v ← 0 next edge; the input is dropped; payload registers may hold stale data; stall_cnt unaffected. Flush has priority over acc and xfer.
- rst=1: m_v=0, s_v=0, in_ready=1, all payload registers 0, stall_cnt=0. Reset mid-stall discards both entries.

Gating and payload:
- wen_out, mem_write_out, mem_read_out and mem_to_reg_out are each the stored bit ANDed with m_v. They read 0 whenever out_valid=0.
- Payload outputs show the main register regardless of m_v.

stall_cnt:
- +1 each edge where m_v & ~out_ready.
- Saturates at 2^CNT_W−1.
- Cleared only by rst.

Hazard outputs:
- fwd_en, fwd_data and load_use are combinational from the main register and hz_raddr*.
- Register 0 never forwards and never raises load_use.

## Timing
- Latency: input accepted at edge N appears on the outputs after edge N (out_valid=1 in cycle N+1).
- Throughput: 1 per cycle with out_ready held high; in_ready stays 1.
- out_ready falling while in_valid stays high: one extra input goes into the skid. in_ready is 0 from the next cycle.
- out_ready rising with s_v=1: main ← skid at that edge. in_ready returns to 1 the following cycle. No entry is lost, duplicated or reordered.
- The handshake holds across any in_valid/out_ready pattern, including both toggling every cycle.
- After rst deasserts: in_ready=1 in the first cycle and out_valid=0 until the first accepted input.

## Test plan
- Streaming: rst, then in_valid=1 for 8 cycles with results 1..8 and out_ready=1 → out_valid from cycle 2; result_out 1..8 on consecutive cycles; in_ready stays 1; stall_cnt=0.
- Backpressure: stream 1..6 and drop out_ready for 3 cycles after item 2 appears → item 3 is held in the skid; in_ready=0 for 3 cycles; items arrive 1..6 in order with no loss or duplication; stall_cnt=3.
- Flush during full skid: main=A, skid=B, in_valid=C, flush=1 → next cycle out_valid=0, in_ready=1, and A, B, C never appear. mem_write_out=0 throughout the bubble.
- Bubble gating: hold an entry with mem_write_in=1, then let it drain with in_valid=0 → mem_write_out and wen_out are 0 while out_valid=0, even though the payload registers still show the old entry.
- Hazards: main holds waddr=5, wen=1, mem_read=1, with hz_raddr2=5 → load_use=1 and fwd_en=0. With mem_read=0 → fwd_en=1 and fwd_data=result_out. With waddr=0 → both 0.
- Saturation and reset: CNT_W=4 with out_valid=1 and out_ready=0 for 20 cycles → stall_cnt stops at 15. Assert rst mid-stall → next cycle stall_cnt=0, out_valid=0, in_ready=1.

Source files
------------

// File: rtl/exe_mem_pipe.sv
// exe_mem_pipe: EXE->MEM pipeline register with a skid-buffered
// valid/ready handshake, synchronous flush, bubble gating of control bits,
// forwarding / load-use hazard outputs and a saturating stall counter.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   flush               drop both held entries and the current input
//   in_valid/in_ready   EXE-side handshake (in_ready comes from a flop)
//   *_in                control bits and payload from EXE
//   out_valid/out_ready MEM-side handshake
//   *_out               control bits (gated by out_valid) and payload
//   hz_raddr1/2         source registers of the instruction now in EXE
//   fwd_en, fwd_data    forwarding of the ALU result held in this stage
//   load_use            load in this stage feeds the instruction in EXE
//   stall_cnt           saturating count of cycles with out_valid & ~out_ready
module exe_mem_pipe #(
    parameter int DSIZE = 32,
    parameter int ASIZE = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             wen_in,
    input  logic             mem_write_in,
    input  logic             mem_read_in,
    input  logic             mem_to_reg_in,
    input  logic [DSIZE-1:0] rdata2_in,
    input  logic [DSIZE-1:0] result_in,
    input  logic [ASIZE-1:0] waddr_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             wen_out,
    output logic             mem_write_out,
    output logic             mem_read_out,
    output logic             mem_to_reg_out,
    output logic [DSIZE-1:0] rdata2_out,
    output logic [DSIZE-1:0] result_out,
    output logic [ASIZE-1:0] waddr_out,
    input  logic [ASIZE-1:0] hz_raddr1,
    input  logic [ASIZE-1:0] hz_raddr2,
    output logic             fwd_en,
    output logic [DSIZE-1:0] fwd_data,
    output logic             load_use,
    output logic [CNT_W-1:0] stall_cnt
);

    // Packed payload: {wen, mem_write, mem_read, mem_to_reg, rdata2, result, waddr}
    localparam int PW = 4 + 2 * DSIZE + ASIZE;

    logic [PW-1:0]    in_pl;
    logic [PW-1:0]    main_q, main_d;
    logic [PW-1:0]    skid_q, skid_d;
    logic             m_v_q, m_v_d;
    logic             s_v_q, s_v_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic             acc;
    logic             xfer;

    assign in_pl = {wen_in, mem_write_in, mem_read_in, mem_to_reg_in,
                    rdata2_in, result_in, waddr_in};

    // in_ready depends only on the skid flop, so a MEM stall never reaches EXE
    // combinationally.
    assign in_ready = ~s_v_q;
    assign acc      = in_valid & ~s_v_q & ~flush;
    assign xfer     = m_v_q & out_ready;

    always_comb begin
        main_d = main_q;
        skid_d = skid_q;
        m_v_d  = m_v_q;
        s_v_d  = s_v_q;
        if (flush) begin
            m_v_d = 1'b0;
            s_v_d = 1'b0;
        end else if (!m_v_q || (xfer && !s_v_q)) begin
            main_d = in_pl;
            m_v_d  = acc;
        end else if (xfer && s_v_q) begin
            // in_ready was low this cycle, so nothing new is accepted here.
            main_d = skid_q;
            m_v_d  = 1'b1;
            s_v_d  = 1'b0;
        end else if (acc) begin
            skid_d = in_pl;
            s_v_d  = 1'b1;
        end
    end

    always_comb begin
        stall_d = stall_q;
        if (m_v_q && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_q  <= '0;
            skid_q  <= '0;
            m_v_q   <= 1'b0;
            s_v_q   <= 1'b0;
            stall_q <= '0;
        end else begin
            main_q  <= main_d;
            skid_q  <= skid_d;
            m_v_q   <= m_v_d;
            s_v_q   <= s_v_d;
            stall_q <= stall_d;
        end
    end

    assign out_valid      = m_v_q;
    assign waddr_out      = main_q[ASIZE-1:0];
    assign result_out     = main_q[ASIZE +: DSIZE];
    assign rdata2_out     = main_q[ASIZE+DSIZE +: DSIZE];
    // Bubbles must never write memory or the register file.
    assign mem_to_reg_out = main_q[PW-4] & m_v_q;
    assign mem_read_out   = main_q[PW-3] & m_v_q;
    assign mem_write_out  = main_q[PW-2] & m_v_q;
    assign wen_out        = main_q[PW-1] & m_v_q;
    assign stall_cnt      = stall_q;

    // Register 0 is hard-wired zero: never forward it, never stall on it.
    assign fwd_data = result_out;
    assign fwd_en   = wen_out & ~mem_read_out & (waddr_out != '0);
    assign load_use = mem_read_out & wen_out & (waddr_out != '0) &
                      ((waddr_out == hz_raddr1) | (waddr_out == hz_raddr2));

endmodule
